// File: rtl/multi_digit_rate_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : multi_digit_rate_counter
// Brief    : Multi-digit BCD/hex up/down counter advanced by a programmable
//            rate divider, with parallel load, wrap pulse and 7-seg outputs.
// Revision : 1.0 - initial release
// ============================================================================
module multi_digit_rate_counter #(
  parameter int DIGITS = 4,
  parameter int BCD    = 1,
  parameter int DIV_W  = 28
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  par_load,
  input  logic [4*DIGITS-1:0]   load,
  input  logic                  up,
  input  logic [DIV_W-1:0]      period,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tick,
  output logic                  carry,
  output logic [7*DIGITS-1:0]   hex
);

  // Largest legal digit value in the selected radix.
  localparam logic [3:0] c_MAX = (BCD != 0) ? 4'd9 : 4'd15;

  logic [DIV_W-1:0]    r_div_cnt;
  logic [4*DIGITS-1:0] r_q;
  logic                r_carry;
  logic [4*DIGITS-1:0] w_next;
  logic                w_wrap;
  logic [4*DIGITS-1:0] w_load_sat;

  // Advance strobe: divider expired, and neither load nor reset is pre-empting it.
  assign tick  = enable & (r_div_cnt == '0) & ~par_load & ~reset;
  assign q     = r_q;
  assign carry = r_carry;

  // Ripple increment/decrement: the chain bit survives a digit only when that
  // digit wraps, so a surviving chain out of the top digit is a full-width wrap.
  always_comb begin
    logic [3:0] w_dig;
    logic       w_chain;
    w_next  = r_q;
    w_chain = 1'b1;
    w_dig   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_dig = r_q[4*i +: 4];
      if (w_chain) begin
        if (up) begin
          if (w_dig >= c_MAX) begin
            w_next[4*i +: 4] = 4'd0;
          end else begin
            w_next[4*i +: 4] = w_dig + 4'd1;
            w_chain          = 1'b0;
          end
        end else begin
          if (w_dig == 4'd0) begin
            w_next[4*i +: 4] = c_MAX;
          end else begin
            w_next[4*i +: 4] = w_dig - 4'd1;
            w_chain          = 1'b0;
          end
        end
      end
    end
    w_wrap = w_chain;
  end

  // Clamp loaded digits into range so decimal mode never holds a non-decimal digit.
  always_comb begin
    logic [3:0] w_ld;
    w_load_sat = load;
    w_ld       = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_ld = load[4*i +: 4];
      if (w_ld > c_MAX) begin
        w_load_sat[4*i +: 4] = c_MAX;
      end
    end
  end

  // State update: reset, then load, then divider/count advance, else hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q       <= '0;
      r_carry   <= 1'b0;
      r_div_cnt <= period;
    end else if (par_load) begin
      r_q       <= w_load_sat;
      r_carry   <= 1'b0;
      r_div_cnt <= period;
    end else if (enable) begin
      if (r_div_cnt == '0) begin
        r_div_cnt <= period;
        r_q       <= w_next;
        r_carry   <= w_wrap;
      end else begin
        r_div_cnt <= r_div_cnt - 1'b1;
        r_carry   <= 1'b0;
      end
    end else begin
      r_carry <= 1'b0;
    end
  end

  // Active-low segment pattern, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_hex
      assign hex[7*g +: 7] = seg7(r_q[4*g +: 4]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_rate_counter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multi_digit_rate_counter
// Brief    : Directed self-checking bench; a decimal and a hex instance share
//            the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_digit_rate_counter;

  logic        clock = 1'b0;
  logic        reset, enable, par_load, up;
  logic [15:0] load;
  logic [27:0] period;
  logic [15:0] q, q_h;
  logic        tick, tick_h, carry, carry_h;
  logic [27:0] hex, hex_h;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] c_S0 = 7'b1000000;

  multi_digit_rate_counter #(.DIGITS(4), .BCD(1), .DIV_W(28)) dut (
    .clock(clock), .reset(reset), .enable(enable), .par_load(par_load),
    .load(load), .up(up), .period(period),
    .q(q), .tick(tick), .carry(carry), .hex(hex)
  );

  multi_digit_rate_counter #(.DIGITS(4), .BCD(0), .DIV_W(28)) dut_h (
    .clock(clock), .reset(reset), .enable(enable), .par_load(par_load),
    .load(load), .up(up), .period(period),
    .q(q_h), .tick(tick_h), .carry(carry_h), .hex(hex_h)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; par_load = 1'b0; load = 16'h0; up = 1'b1; period = 28'd3;
    #1;
    check_value("tick_in_reset", {31'd0, tick}, 32'd0);
    step();
    check_value("rst_q", {16'd0, q}, 32'h0);
    check_value("rst_carry", {31'd0, carry}, 32'd0);
    check_value("rst_hex", {4'd0, hex}, {4'd0, c_S0, c_S0, c_S0, c_S0});

    // Free run at period 3: tick on every fourth cycle.
    reset = 1'b0;
    #1;
    for (int k = 1; k <= 4; k++) begin
      check_value($sformatf("p3_tick_%0d", k), {31'd0, tick}, (k == 4) ? 32'd1 : 32'd0);
      step();
    end
    check_value("p3_q_4", {16'd0, q}, 32'h0001);
    for (int k = 0; k < 36; k++) step();
    check_value("p3_q_40", {16'd0, q}, 32'h0010);
    check_value("p3_carry", {31'd0, carry}, 32'd0);

    // Load 9999, period 0, count up across the full wrap.
    period = 28'd0; load = 16'h9999; par_load = 1'b1;
    #1;
    check_value("load_masks_tick", {31'd0, tick}, 32'd0);
    step();
    check_value("ld9999_q", {16'd0, q}, 32'h9999);
    par_load = 1'b0;
    #1;
    check_value("p0_tick", {31'd0, tick}, 32'd1);
    step();
    check_value("wrap_up_q", {16'd0, q}, 32'h0000);
    check_value("wrap_up_carry", {31'd0, carry}, 32'd1);
    check_value("wrap_up_hex", {4'd0, hex}, {4'd0, c_S0, c_S0, c_S0, c_S0});
    check_value("hex_999a_q", {16'd0, q_h}, 32'h999A);
    check_value("hex_999a_carry", {31'd0, carry_h}, 32'd0);
    check_value("hex_seg_a", {25'd0, hex_h[6:0]}, {25'd0, 7'b0001000});
    step();
    check_value("after_wrap_q", {16'd0, q}, 32'h0001);
    check_value("after_wrap_carry", {31'd0, carry}, 32'd0);

    // Load zero and count down across the full wrap.
    up = 1'b0; load = 16'h0000; par_load = 1'b1;
    step();
    check_value("ld0_carry", {31'd0, carry}, 32'd0);
    par_load = 1'b0;
    step();
    check_value("dn_hex_q", {16'd0, q_h}, 32'hFFFF);
    check_value("dn_hex_carry", {31'd0, carry_h}, 32'd1);
    check_value("dn_bcd_q", {16'd0, q}, 32'h9999);
    check_value("dn_bcd_carry", {31'd0, carry}, 32'd1);
    step();
    check_value("dn_hex_q2", {16'd0, q_h}, 32'hFFFE);
    check_value("dn_hex_carry2", {31'd0, carry_h}, 32'd0);
    check_value("dn_hex_seg_e", {25'd0, hex_h[6:0]}, {25'd0, 7'b0000110});
    check_value("dn_bcd_q2", {16'd0, q}, 32'h9998);

    // Load saturation; load held across a would-be tick.
    up = 1'b1; load = 16'h12AF; par_load = 1'b1;
    #1;
    check_value("sat_tick_masked", {31'd0, tick}, 32'd0);
    step();
    check_value("sat_q", {16'd0, q}, 32'h1299);
    check_value("sat_hex", {4'd0, hex}, {4'd0, 7'b1111001, 7'b0100100, 7'b0010000, 7'b0010000});
    check_value("nosat_q", {16'd0, q_h}, 32'h12AF);
    check_value("nosat_hex", {4'd0, hex_h}, {4'd0, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});
    step();
    check_value("load_wins_q", {16'd0, q}, 32'h1299);
    par_load = 1'b0;
    step();
    check_value("sat_inc_q", {16'd0, q}, 32'h1300);
    check_value("nosat_inc_q", {16'd0, q_h}, 32'h12B0);

    // Enable freeze and a period change mid-countdown.
    period = 28'd4; load = 16'h0000; par_load = 1'b1;
    step();
    par_load = 1'b0;
    step();
    step();
    period = 28'd1; enable = 1'b0; up = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_value($sformatf("frz_tick_%0d", k), {31'd0, tick}, 32'd0);
    end
    check_value("frz_q", {16'd0, q}, 32'h0000);
    up = 1'b1; enable = 1'b1;
    #1;
    check_value("resume_tick0", {31'd0, tick}, 32'd0);
    step();
    check_value("resume_tick1", {31'd0, tick}, 32'd0);
    step();
    check_value("resume_tick2", {31'd0, tick}, 32'd1);
    check_value("dir_toggle_q", {16'd0, q}, 32'h0000);
    step();
    check_value("resume_q1", {16'd0, q}, 32'h0001);
    check_value("newper_tick0", {31'd0, tick}, 32'd0);
    step();
    check_value("newper_tick1", {31'd0, tick}, 32'd1);
    step();
    check_value("newper_q2", {16'd0, q}, 32'h0002);

    // Reset together with load and a pending tick.
    step();
    check_value("pre_rst_tick", {31'd0, tick}, 32'd1);
    reset = 1'b1; par_load = 1'b1; load = 16'h5555; period = 28'd2;
    #1;
    check_value("rst_masks_tick", {31'd0, tick}, 32'd0);
    step();
    check_value("rst2_q", {16'd0, q}, 32'h0000);
    check_value("rst2_q_h", {16'd0, q_h}, 32'h0000);
    check_value("rst2_carry", {31'd0, carry}, 32'd0);
    reset = 1'b0; par_load = 1'b0;
    #1;
    for (int k = 1; k <= 3; k++) begin
      check_value($sformatf("rst2_tick_%0d", k), {31'd0, tick}, (k == 3) ? 32'd1 : 32'd0);
      step();
    end
    check_value("rst2_q1", {16'd0, q}, 32'h0001);
    check_value("rst2_q1_h", {16'd0, q_h}, 32'h0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
